encrypter_result_arbiter: RTL and testbench
===========================================

# encrypter_result_arbiter

Collects ciphertext words from the pool of encrypters and returns them to the host over the 4-bit QSPI output in the same order the words were dispatched. Dispatch is strict round-robin starting at encrypter 0, so the block grants the shared output path to one encrypter at a time in that order. Each granted word is serialized into nibbles with a valid/ready handshake. It sits between the encrypter array outputs and the QSPI transmit pins, alongside the input-side dispatcher.

## Interface
- NUM_ENCRYPTERS, 4: encrypters in the pool; ≥2.
- ENCRYPTER_WIDTH, 32: ciphertext word width; multiple of 4.
- TIMEOUT_CYCLES, 1024: watchdog limit, used only with RESULT_TIMEOUT_EN.

- clk  in  1: clock; all logic on rising edge.
- reset  in  1: reset, synchronous, active-high.
- dispatch_pulse  in  1: one-cycle pulse per word handed to an encrypter, i.e. OR of dispatcher data_ready strobes.
- enc_result_valid  in  NUM_ENCRYPTERS: bit i high while encrypter i holds a finished word.
- enc_result_data  in  NUM_ENCRYPTERS*ENCRYPTER_WIDTH: flat bus; encrypter i occupies bits [i*W +: W].
- enc_result_ack  out  NUM_ENCRYPTERS: one-cycle pulse; encrypter i may drop valid after it.
- qspi_out_data  out  4: current nibble.
- qspi_out_valid  out  1: nibble valid.
- qspi_out_ready  in  1: host accepts the nibble on an edge where valid and ready are both high.
- busy  out  1: high while serializing.
- overflow_err  out  1: sticky flag; a dispatch arrived while outstanding == NUM_ENCRYPTERS.
- timeout_err  out  1: sticky flag; an expected result was skipped.

## Operation
- Registers:
  - next_idx: 0..N-1, the encrypter owed next.
  - outstanding: 0..N, words dispatched but not yet returned.
  - shift register: W bits.
  - nib_cnt: 0..W/4-1, nibble counter.
  - wd_cnt: watchdog counter.
- Reset values: all outputs 0; next_idx 0; outstanding 0; both error flags cleared.
- State IDLE:
  - If outstanding>0 and enc_result_valid[next_idx]: latch that encrypter's word, pulse enc_result_ack[next_idx], set nib_cnt=0, go SHIFT.
  - valid bits of other encrypters are ignored, never acked and never reordered.
  - With outstanding==0, all result valids are ignored.
- State SHIFT:
  - qspi_out_valid=1; qspi_out_data=word[nib_cnt*4 +: 4]. Nibble 0 is bits [3:0], the same packing the dispatcher uses.
  - On each accepted transfer, nib_cnt increments.
  - On acceptance of nibble W/4-1: next_idx increments, wrapping N-1→0; outstanding decrements; go IDLE.
- outstanding:
  - Increments on dispatch_pulse.
  - A dispatch and a completion in the same cycle leave it unchanged.
  - A dispatch at N holds it at N and sets overflow_err.
- busy equals (state==SHIFT).

## Timing
- enc_result_valid[next_idx] sampled high at edge t:
  - enc_result_ack visible from t for exactly one cycle.
  - First nibble valid from t.
- With qspi_out_ready held high, a word takes W/4 cycles in SHIFT plus 1 IDLE cycle, i.e. 9 cycles for W=32.
- qspi_out_valid drops for at least one cycle between words.
- qspi_out_data and qspi_out_valid are stable while ready is low.
- Reset mid-SHIFT: the word is discarded with no further nibbles. The next edge gives reset values, so the host sees a truncated word.

## Configuration
- RESULT_TIMEOUT_EN defined:
  - In IDLE with outstanding>0, wd_cnt increments each cycle. It clears on a grant or on leaving IDLE.
  - When wd_cnt reaches TIMEOUT_CYCLES-1 without a grant: set timeout_err, advance next_idx, decrement outstanding, emit nothing, clear wd_cnt.
- Undefined: no watchdog; the block waits indefinitely; timeout_err is tied 0.

## Structure
- Shared package encrypter_pkg:
  - NUM_ENCRYPTERS, ENCRYPTER_WIDTH, QSPI_NIBBLES (=W/4).
  - The index width constant.
  - The arb_state_t enum (IDLE, SHIFT).
- One sub-module, nibble_serializer: load, W-bit word, valid/ready nibble output, last-accepted pulse. The arbiter keeps ordering, counters and the watchdog.

## Test plan
- 1 dispatch; encrypter 0 valid with 0x89ABCDEF; ready high → ack[0] pulses once; nibbles F,E,D,C,B,A,9,8 over 8 consecutive cycles; next_idx=1.
- 2 dispatches; encrypter 1 valid before encrypter 0 → no ack[1] until encrypter 0's word has fully serialized; output order is word0 then word1.
- Ready toggling 1,0,0,1 during SHIFT → data frozen during stall; no nibble duplicated or lost.
- 5 dispatches with N=4 and no results → outstanding=4; overflow_err=1.
- RESULT_TIMEOUT_EN, TIMEOUT_CYCLES=16, encrypter 0 never valid → timeout_err after 16 cycles; encrypter 1's word is emitted next.
- Reset asserted at nibble 3 → next cycle: valid=0, ack=0, errors cleared, next_idx=0.

Source files
------------

// File: rtl/encrypter_pkg.sv
// ----------------------------------------------------------------------------
// encrypter_pkg
// Constants and types shared by the encrypter result path: pool size,
// ciphertext word width, nibbles per word, encrypter index width and the
// arbiter state type.
// ----------------------------------------------------------------------------
package encrypter_pkg;

    localparam int NUM_ENCRYPTERS  = 4;
    localparam int ENCRYPTER_WIDTH = 32;
    localparam int QSPI_NIBBLES    = ENCRYPTER_WIDTH / 4;
    localparam int ENC_IDX_W       = (NUM_ENCRYPTERS > 1) ? $clog2(NUM_ENCRYPTERS) : 1;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } arb_state_t;

endpackage

// File: rtl/encrypter_result_arbiter_nibble_serializer.sv
// ----------------------------------------------------------------------------
// nibble_serializer
// Holds one ciphertext word and hands it out four bits at a time over a
// valid/ready handshake, least-significant nibble first.
//
// Ports:
//   clk, reset     clock, synchronous active-high reset
//   load           capture word and start serializing (only while idle)
//   word           word to serialize
//   out_data       current nibble (0 while idle)
//   out_valid      nibble valid
//   out_ready      consumer accepts the nibble when valid and ready are high
//   last_accepted  combinational pulse: final nibble accepted this cycle
// ----------------------------------------------------------------------------
module nibble_serializer
    import encrypter_pkg::*;
#(
    parameter int WIDTH = ENCRYPTER_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] word,
    output logic [3:0]       out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             last_accepted
);

    localparam int NIBBLES = WIDTH / 4;
    localparam int NIB_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [NIB_W-1:0] LAST_NIB = NIB_W'(NIBBLES - 1);

    logic             active;
    logic [WIDTH-1:0] sreg;
    logic [NIB_W-1:0] nib_cnt;
    logic             accept;

    assign accept        = active && out_ready;
    assign last_accepted = accept && (nib_cnt == LAST_NIB);

    // Data output is forced to zero while idle so the pins read 0 out of reset.
    assign out_data  = active ? sreg[3:0] : 4'h0;
    assign out_valid = active;

    always_ff @(posedge clk) begin
        if (reset) begin
            active  <= 1'b0;
            nib_cnt <= '0;
        end else if (load) begin
            active  <= 1'b1;
            nib_cnt <= '0;
        end else if (accept) begin
            if (last_accepted) begin
                active  <= 1'b0;
                nib_cnt <= '0;
            end else begin
                nib_cnt <= nib_cnt + 1'b1;
            end
        end
    end

    // The word itself needs no reset; nothing reads it while inactive.
    always_ff @(posedge clk) begin
        if (load) begin
            sreg <= word;
        end else if (accept) begin
            sreg <= sreg >> 4;
        end
    end

endmodule

// File: rtl/encrypter_result_arbiter.sv
// ----------------------------------------------------------------------------
// encrypter_result_arbiter
// Returns ciphertext words from the encrypter pool to the host over the 4-bit
// QSPI output, in the same strict round-robin order the dispatcher handed the
// plaintext out (starting at encrypter 0). Only the encrypter owed next is
// ever granted; finished words from other encrypters wait their turn.
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   dispatch_pulse    one pulse per word handed to an encrypter
//   enc_result_valid  per-encrypter "finished word held"
//   enc_result_data   flat bus, encrypter i at [i*W +: W]
//   enc_result_ack    one-cycle pulse to the granted encrypter
//   qspi_out_data     current nibble
//   qspi_out_valid    nibble valid
//   qspi_out_ready    host accepts nibble when valid and ready are high
//   busy              high while a word is being serialized
//   overflow_err      sticky: dispatch arrived with the pool already full
//   timeout_err       sticky: an owed result was skipped by the watchdog
//
// Build option: define RESULT_TIMEOUT_EN to enable the result watchdog.
// Without it the arbiter waits indefinitely and timeout_err is tied low.
// ----------------------------------------------------------------------------
module encrypter_result_arbiter #(
    parameter int NUM_ENCRYPTERS  = encrypter_pkg::NUM_ENCRYPTERS,
    parameter int ENCRYPTER_WIDTH = encrypter_pkg::ENCRYPTER_WIDTH,
    parameter int TIMEOUT_CYCLES  = 1024
) (
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic                                      dispatch_pulse,
    input  logic [NUM_ENCRYPTERS-1:0]                 enc_result_valid,
    input  logic [NUM_ENCRYPTERS*ENCRYPTER_WIDTH-1:0] enc_result_data,
    output logic [NUM_ENCRYPTERS-1:0]                 enc_result_ack,
    output logic [3:0]                                qspi_out_data,
    output logic                                      qspi_out_valid,
    input  logic                                      qspi_out_ready,
    output logic                                      busy,
    output logic                                      overflow_err,
    output logic                                      timeout_err
);

    import encrypter_pkg::*;

    localparam int IDX_W = (NUM_ENCRYPTERS > 1) ? $clog2(NUM_ENCRYPTERS) : 1;
    localparam int OUT_W = $clog2(NUM_ENCRYPTERS + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ENCRYPTERS - 1);
    localparam logic [OUT_W-1:0] FULL     = OUT_W'(NUM_ENCRYPTERS);

    arb_state_t                 state;
    logic [IDX_W-1:0]           next_idx;
    logic [OUT_W-1:0]           outstanding;
    logic                       grant;
    logic                       word_done;
    logic                       skip;
    logic                       advance;
    logic [ENCRYPTER_WIDTH-1:0] granted_word;

    // Only the encrypter owed next can be granted, and only if a word is owed.
    assign grant        = (state == IDLE) && (outstanding != '0) && enc_result_valid[next_idx];
    assign granted_word = enc_result_data[int'(next_idx)*ENCRYPTER_WIDTH +: ENCRYPTER_WIDTH];
    // A result slot is retired either by finishing its word or by the watchdog.
    assign advance      = word_done || skip;
    assign busy         = (state == SHIFT);

    nibble_serializer #(
        .WIDTH(ENCRYPTER_WIDTH)
    ) u_serializer (
        .clk          (clk),
        .reset        (reset),
        .load         (grant),
        .word         (granted_word),
        .out_data     (qspi_out_data),
        .out_valid    (qspi_out_valid),
        .out_ready    (qspi_out_ready),
        .last_accepted(word_done)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else if (grant) begin
            state <= SHIFT;
        end else if (word_done) begin
            state <= IDLE;
        end
    end

    // Ack is registered so it lines up with the first nibble.
    always_ff @(posedge clk) begin
        if (reset) begin
            enc_result_ack <= '0;
        end else if (grant) begin
            enc_result_ack <= NUM_ENCRYPTERS'(1) << next_idx;
        end else begin
            enc_result_ack <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            next_idx <= '0;
        end else if (advance) begin
            next_idx <= (next_idx == LAST_IDX) ? '0 : next_idx + 1'b1;
        end
    end

    // Simultaneous dispatch and retirement cancel out; a dispatch into a full
    // pool is counted as an error and the count saturates.
    always_ff @(posedge clk) begin
        if (reset) begin
            outstanding  <= '0;
            overflow_err <= 1'b0;
        end else begin
            if (dispatch_pulse && !advance && (outstanding != FULL)) begin
                outstanding <= outstanding + 1'b1;
            end else if (!dispatch_pulse && advance) begin
                outstanding <= outstanding - 1'b1;
            end
            if (dispatch_pulse && (outstanding == FULL)) begin
                overflow_err <= 1'b1;
            end
        end
    end

`ifdef RESULT_TIMEOUT_EN
    localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT_CYCLES - 1);

    logic [WD_W-1:0] wd_cnt;
    logic            waiting;
    logic            timeout_flag;

    // Waiting means a result is owed but the owed encrypter is not offering it.
    assign waiting     = (state == IDLE) && (outstanding != '0) && !grant;
    assign skip        = waiting && (wd_cnt == WD_LIMIT);
    assign timeout_err = timeout_flag;

    always_ff @(posedge clk) begin
        if (reset) begin
            wd_cnt       <= '0;
            timeout_flag <= 1'b0;
        end else if (skip) begin
            wd_cnt       <= '0;
            timeout_flag <= 1'b1;
        end else if (waiting) begin
            wd_cnt <= wd_cnt + 1'b1;
        end else begin
            wd_cnt <= '0;
        end
    end
`else
    assign skip        = 1'b0;
    assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_encrypter_result_arbiter.sv
// ----------------------------------------------------------------------------
// tb_encrypter_result_arbiter
// Directed bench for encrypter_result_arbiter (N=4, W=32, TIMEOUT_CYCLES=16).
// Inputs are driven on the falling edge, outputs sampled on the falling edge.
// ----------------------------------------------------------------------------
module tb_encrypter_result_arbiter;

    localparam int N = 4;
    localparam int W = 32;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           dispatch_pulse = 1'b0;
    logic [N-1:0]   enc_result_valid = '0;
    logic [N*W-1:0] enc_result_data = '0;
    logic [N-1:0]   enc_result_ack;
    logic [3:0]     qspi_out_data;
    logic           qspi_out_valid;
    logic           qspi_out_ready = 1'b1;
    logic           busy;
    logic           overflow_err;
    logic           timeout_err;

    int total = 0;
    int bad   = 0;

    encrypter_result_arbiter #(
        .NUM_ENCRYPTERS (N),
        .ENCRYPTER_WIDTH(W),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .dispatch_pulse  (dispatch_pulse),
        .enc_result_valid(enc_result_valid),
        .enc_result_data (enc_result_data),
        .enc_result_ack  (enc_result_ack),
        .qspi_out_data   (qspi_out_data),
        .qspi_out_valid  (qspi_out_valid),
        .qspi_out_ready  (qspi_out_ready),
        .busy            (busy),
        .overflow_err    (overflow_err),
        .timeout_err     (timeout_err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish in time");
        $fatal(1, "bench timeout");
    end

    typedef struct {
        int          idx;
        logic [31:0] word;
        logic [31:0] stream;   // nibbles in wire order, first nibble in [31:28]
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_word(input int idx, input logic [31:0] word);
        enc_result_data[idx*W +: W] = word;
        enc_result_valid[idx]       = 1'b1;
    endtask

    task automatic dispatch();
        dispatch_pulse = 1'b1;
        @(negedge clk);
        dispatch_pulse = 1'b0;
    endtask

    task automatic check_idle_outputs(input string name);
        chk({name, "_valid"},    qspi_out_valid, 0);
        chk({name, "_ack"},      enc_result_ack, 0);
        chk({name, "_busy"},     busy, 0);
        chk({name, "_data"},     qspi_out_data, 0);
        chk({name, "_overflow"}, overflow_err, 0);
        chk({name, "_timeout"},  timeout_err, 0);
    endtask

    // Wait for the grant of encrypter idx, then collect one word while driving
    // ready from pat (bit c on cycle c, then held high).
    task automatic collect_word(input int idx, input logic [31:0] exp_stream,
                                input logic [15:0] pat, input string name);
        int          waited;
        int          got_n;
        int          c;
        logic [31:0] got;
        logic [3:0]  prev;
        logic        prev_stall;
        waited = 0;
        @(negedge clk);
        while (enc_result_ack == '0 && waited < 30) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 30) begin
            total++;
            bad++;
            $display("FAIL %s_grant_wait: no ack within 30 cycles, required ack %0h", name, 1 << idx);
            return;
        end
        chk({name, "_ack"}, enc_result_ack, N'(1) << idx);
        chk({name, "_busy"}, busy, 1);
        enc_result_valid[idx] = 1'b0;
        got = '0;
        got_n = 0;
        c = 0;
        prev = 4'h0;
        prev_stall = 1'b0;
        while (got_n < 8 && c < 40) begin
            if (c > 0) @(negedge clk);
            qspi_out_ready = (c < 16) ? pat[c] : 1'b1;
            if (c == 1) chk({name, "_ack_one_cycle"}, enc_result_ack, 0);
            chk({name, "_valid_held"}, qspi_out_valid, 1);
            if (prev_stall) chk({name, "_stall_data"}, qspi_out_data, prev);
            if (qspi_out_ready) begin
                got = {got[27:0], qspi_out_data};
                got_n++;
            end
            prev_stall = !qspi_out_ready;
            prev = qspi_out_data;
            c++;
        end
        @(negedge clk);
        chk({name, "_gap_valid"}, qspi_out_valid, 0);
        chk({name, "_stream"}, got, exp_stream);
        qspi_out_ready = 1'b1;
    endtask

    initial begin
        int          waited;
        int          n;
        logic        seen;
        logic [31:0] got;

        vecs[0] = '{0, 32'h89ABCDEF, 32'hFEDCBA98};
        vecs[1] = '{1, 32'h12345678, 32'h87654321};
        vecs[2] = '{2, 32'h00000000, 32'h00000000};
        vecs[3] = '{3, 32'hFFFFFFFF, 32'hFFFFFFFF};
        vecs[4] = '{0, 32'hA5A5A5A5, 32'h5A5A5A5A};
        vecs[5] = '{1, 32'h0F1E2D3C, 32'hC3D2E1F0};

        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        check_idle_outputs("reset");

        // Single-word transactions in round-robin order.
        for (int i = 0; i < 6; i++) begin
            set_word(vecs[i].idx, vecs[i].word);
            dispatch();
            collect_word(vecs[i].idx, vecs[i].stream, 16'hFFFF, $sformatf("vec%0d", i));
        end

        // Encrypter 1 finishes first but must wait behind encrypter 0.
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        dispatch();
        dispatch();
        set_word(1, 32'h55AA33CC);
        seen = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            seen = seen | (|enc_result_ack) | qspi_out_valid;
        end
        chk("order_no_early_grant", seen, 0);
        set_word(0, 32'h0BADCAFE);
        collect_word(0, 32'hEFACDAB0, 16'hFFFF, "order_w0");
        collect_word(1, 32'hCC33AA55, 16'hFFFF, "order_w1");

        // Host stalls: ready 1,0,0,1 then high.
        set_word(2, 32'h76543210);
        dispatch();
        collect_word(2, 32'h01234567, 16'hFFF9, "stall");

        // Five dispatches into a pool of four.
        for (int k = 0; k < 4; k++) dispatch();
        chk("overflow_not_yet", overflow_err, 0);
        dispatch();
        chk("overflow_set", overflow_err, 1);
        set_word(3, 32'h11112222);
        set_word(0, 32'hDEADBEEF);
        set_word(1, 32'h0000FFFF);
        set_word(2, 32'h80000001);
        collect_word(3, 32'h22221111, 16'hFFFF, "ovf_w3");
        collect_word(0, 32'hFEEBDAED, 16'hFFFF, "ovf_w0");
        collect_word(1, 32'hFFFF0000, 16'hFFFF, "ovf_w1");
        collect_word(2, 32'h10000008, 16'hFFFF, "ovf_w2");
        set_word(3, 32'h13579BDF);
        seen = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            seen = seen | (|enc_result_ack);
        end
        chk("outstanding_saturated", seen, 0);
        chk("overflow_sticky", overflow_err, 1);

        // Reset while nibble 3 is on the pins.
        dispatch();
        waited = 0;
        @(negedge clk);
        while (enc_result_ack == '0 && waited < 30) begin
            @(negedge clk);
            waited++;
        end
        chk("rst_mid_ack", enc_result_ack, 4'b1000);
        enc_result_valid[3] = 1'b0;
        got = '0;
        for (int c = 0; c < 3; c++) begin
            got = {got[27:0], qspi_out_data};
            @(negedge clk);
        end
        chk("rst_mid_nibbles", got[11:0], 12'hFDB);
        chk("rst_mid_nib3", qspi_out_data, 4'h9);
        reset = 1'b1;
        @(negedge clk);
        check_idle_outputs("rst_mid");
        reset = 1'b0;
        @(negedge clk);
        chk("rst_mid_no_resume", qspi_out_valid, 0);
        set_word(3, 32'h99999999);
        set_word(0, 32'h2468ACE0);
        dispatch();
        collect_word(0, 32'h0ECA8642, 16'hFFFF, "post_rst_idx0");
        enc_result_valid = '0;

`ifdef RESULT_TIMEOUT_EN
        // Encrypter 0 never answers; the watchdog skips it.
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        dispatch();
        dispatch();
        set_word(1, 32'hCAFEF00D);
        seen = 1'b0;
        n = 0;
        while (!timeout_err && n < 40) begin
            @(negedge clk);
            n++;
            seen = seen | (|enc_result_ack);
        end
        chk("timeout_set", timeout_err, 1);
        chk("timeout_no_early_ack", seen, 0);
        chk("timeout_latency_ok", (n >= 13 && n <= 17), 1);
        collect_word(1, 32'hD00FEFAC, 16'hFFFF, "timeout_next");
        chk("timeout_sticky", timeout_err, 1);
        enc_result_valid = '0;
`else
        // No watchdog: a missing result is waited for indefinitely.
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        dispatch();
        dispatch();
        set_word(1, 32'hCAFEF00D);
        seen = 1'b0;
        for (n = 0; n < 40; n++) begin
            @(negedge clk);
            seen = seen | (|enc_result_ack) | timeout_err;
        end
        chk("no_watchdog_waits", seen, 0);
        enc_result_valid = '0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
